// File: rtl/frame_dump_uart.sv
// frame_dump_uart: reads a W_RES x H_RES frame from three colour buffers in
// raster order and sends each pixel over an 8N1 UART as bytes R, G, B.
// Ports: clock; reset (sync, active-high); start (one-cycle dump request);
//   red_in/green_in/blue_in (buffer data); rd_x/rd_y (buffer coordinates);
//   tx (serial line, idle high); busy (dump running); done (completion pulse).
// Timing: per pixel ADDR 1 + WAIT RD_LAT + LOAD 1 + SEND 30*BAUD_DIV + NEXT 1
//   cycles. Start-to-done is W_RES*H_RES*(RD_LAT+3+30*BAUD_DIV)+2 cycles,
//   counting both the cycle start is high and the cycle done is high.
module frame_dump_uart #(
    parameter int W_RES    = 640,
    parameter int H_RES    = 480,
    parameter int BAUD_DIV = 434,
    parameter int RD_LAT   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  red_in,
    input  logic [7:0]  green_in,
    input  logic [7:0]  blue_in,
    output logic [10:0] rd_x,
    output logic [10:0] rd_y,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(RD_LAT - 1);
    localparam logic [10:0]   X_LAST    = 11'(W_RES - 1);
    localparam logic [10:0]   Y_LAST    = 11'(H_RES - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, WAIT, LOAD, SEND, NEXT, FIN
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [23:0]   pix_q, pix_d;
    logic [10:0]   x_d, y_d;
    logic [7:0]    cur_byte;
    logic          tx_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            lat_q   <= '0;
            pix_q   <= '0;
            rd_x    <= '0;
            rd_y    <= '0;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            lat_q   <= lat_d;
            pix_q   <= pix_d;
            rd_x    <= x_d;
            rd_y    <= y_d;
            tx      <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        lat_d   = lat_q;
        pix_d   = pix_q;
        x_d     = rd_x;
        y_d     = rd_y;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                lat_d   = '0;
                state_d = (RD_LAT == 0) ? LOAD : WAIT;
            end
            WAIT: begin
                if (lat_q == LAT_LAST) state_d = LOAD;
                else lat_d = lat_q + 1'b1;
            end
            LOAD: begin
                pix_d   = {blue_in, green_in, red_in};
                baud_d  = '0;
                bit_d   = '0;
                byte_d  = '0;
                state_d = SEND;
            end
            SEND: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d = '0;
                        if (byte_q == 2'd2) begin
                            byte_d  = '0;
                            state_d = NEXT;
                        end else begin
                            byte_d = byte_q + 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            NEXT: begin
                if (rd_x == X_LAST && rd_y == Y_LAST) begin
                    state_d = FIN;
                end else begin
                    state_d = ADDR;
                    if (rd_x < X_LAST) begin
                        x_d = rd_x + 1'b1;
                    end else begin
                        x_d = '0;
                        y_d = rd_y + 1'b1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the next-cycle counters, so the line value
    // always matches the bit position the counters will hold.
    always_comb begin
        tx_d = 1'b1;
        unique case (byte_d)
            2'd1:    cur_byte = pix_d[15:8];
            2'd2:    cur_byte = pix_d[23:16];
            default: cur_byte = pix_d[7:0];
        endcase
        if (state_d == SEND) begin
            if (bit_d == 4'd0) tx_d = 1'b0;
            else if (bit_d == 4'd9) tx_d = 1'b1;
            else tx_d = cur_byte[3'(bit_d - 4'd1)];
        end
    end

    assign busy = (state_q != IDLE) && (state_q != FIN);
    assign done = (state_q == FIN);

endmodule

// File: tb/tb_frame_dump_uart.sv
// tb_frame_dump_uart: directed bench with a buffer model, UART decoder
// and byte scoreboard for frame_dump_uart on a 2x2 frame.
`timescale 1ns/1ps
module tb_frame_dump_uart;

    localparam int W     = 2;
    localparam int H     = 2;
    localparam int B     = 4;
    localparam int L     = 1;
    localparam int PIX   = L + 3 + 30 * B;
    localparam int TOTAL = W * H * PIX + 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  red_in = '0;
    logic [7:0]  green_in = '0;
    logic [7:0]  blue_in = '0;
    logic [10:0] rd_x;
    logic [10:0] rd_y;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rmode = 0;
    int tog_s = 0;
    int rx_count = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    frame_dump_uart #(
        .W_RES(W), .H_RES(H), .BAUD_DIV(B), .RD_LAT(L)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .rd_x(rd_x), .rd_y(rd_y), .tx(tx), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] r0, input logic [7:0] r1,
                              input logic [7:0] r2, input logic [7:0] r3);
        logic [7:0] r [4];
        r = '{r0, r1, r2, r3};
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(r[k]);
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'h3C);
        end
    endtask

    task automatic wait_done(input string tag, output int dcyc);
        bit got;
        got  = 1'b0;
        dcyc = -1;
        for (int i = 0; i < 3 * TOTAL; i++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                got  = 1'b1;
                dcyc = cyc;
                break;
            end
        end
        checks++;
        assert (got) else begin
            failures++;
            $error("FAIL %s done_timeout observed=0 expected=1", tag);
        end
    endtask

    // Buffer model with one cycle of read latency. Mode 1 scrambles red
    // every cycle except the LOAD cycle of each pixel; mode 2 forces 0x81.
    always @(posedge clock) begin
        int c;
        int k;
        c = cyc + 1;
        cyc <= c;
        green_in <= 8'hA5;
        blue_in  <= 8'h3C;
        k = (c - tog_s - 3) / PIX;
        if (rmode == 2) begin
            red_in <= 8'h81;
        end else if (rmode == 1) begin
            if (c >= tog_s + 3 && (c - tog_s - 3) % PIX == 0 && k < W * H)
                red_in <= 8'(8'hC0 + k);
            else
                red_in <= 8'($urandom);
        end else begin
            red_in <= 8'(rd_x * 16 + rd_y);
        end
    end

    // UART decoder: samples mid-bit, checks framing, scores each byte.
    int         rx_t = 0;
    bit         rx_on = 1'b0;
    logic [7:0] rx_sh = '0;
    always @(negedge clock) begin
        if (reset) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % B == B / 2) begin
                if (rx_t / B == 0) begin
                    chk("rx_start_bit", 32'(tx), 0);
                end else if (rx_t / B < 9) begin
                    rx_sh = {tx, rx_sh[7:1]};
                end else begin
                    chk("rx_stop_bit", 32'(tx), 1);
                    rx_count++;
                    rx_on = 1'b0;
                    checks++;
                    assert (exp_q.size() > 0) else begin
                        failures++;
                        $error("FAIL rx_extra_byte observed=%0h expected=none",
                               rx_sh);
                    end
                    if (exp_q.size() > 0)
                        chk("rx_byte", 32'(rx_sh), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    always @(negedge clock) begin
        if (done === 1'b1) begin
            done_cnt++;
            chk("busy_low_with_done", 32'(busy), 0);
        end
    end

    initial begin
        int s;
        int d;
        int bad;
        logic [9:0] pat;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_tx", 32'(tx), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_rd_x", 32'(rd_x), 0);
        chk("reset_rd_y", 32'(rd_y), 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Full frame with a second start while busy.
        rmode = 0;
        push_frame(8'h00, 8'h10, 8'h01, 8'h11);
        rx_count = 0;
        done_cnt = 0;
        start = 1'b1;
        s = cyc;
        chk("idle_busy", 32'(busy), 0);
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("start_rd_x", 32'(rd_x), 0);
        chk("start_rd_y", 32'(rd_y), 0);
        repeat (50) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done("dump_a", d);
        chk("duration_a", 32'(d - s + 1), TOTAL);
        chk("fin_rd_x", 32'(rd_x), W - 1);
        chk("fin_rd_y", 32'(rd_y), H - 1);
        chk("fin_tx", 32'(tx), 1);
        @(negedge clock);
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_after_fin", 32'(busy), 0);
        repeat (20) @(negedge clock);
        chk("bytes_a", 32'(rx_count), 12);
        chk("done_count_a", 32'(done_cnt), 1);
        chk("sb_empty_a", 32'(exp_q.size()), 0);

        // Bit-level framing of 0x81.
        rmode = 2;
        push_frame(8'h81, 8'h81, 8'h81, 8'h81);
        rx_count = 0;
        done_cnt = 0;
        start = 1'b1;
        s = cyc;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        chk("load_tx_idle", 32'(tx), 1);
        @(negedge clock);
        pat = 10'b1100000010;
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("frame_0x81_c%0d", i), 32'(tx), 32'(pat[i / B]));
            @(negedge clock);
        end
        wait_done("dump_b", d);
        chk("duration_b", 32'(d - s + 1), TOTAL);
        repeat (20) @(negedge clock);
        chk("bytes_b", 32'(rx_count), 12);
        chk("sb_empty_b", 32'(exp_q.size()), 0);

        // Red changes every cycle; only the LOAD-cycle value may be sent.
        rmode = 1;
        push_frame(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        rx_count = 0;
        start = 1'b1;
        s = cyc;
        tog_s = s;
        @(negedge clock);
        start = 1'b0;
        wait_done("dump_c", d);
        repeat (20) @(negedge clock);
        rmode = 0;
        chk("bytes_c", 32'(rx_count), 12);
        chk("sb_empty_c", 32'(exp_q.size()), 0);

        // Reset in frame bit 5 of the G byte of pixel (1,0).
        push_frame(8'h00, 8'h10, 8'h01, 8'h11);
        rx_count = 0;
        done_cnt = 0;
        start = 1'b1;
        s = cyc;
        @(negedge clock);
        start = 1'b0;
        repeat (4 + PIX + 15 * B) @(negedge clock);
        chk("pre_reset_cycle", 32'(cyc - s), 4 + PIX + 15 * B + 1);
        chk("pre_reset_tx", 32'(tx), 0);
        reset = 1'b1;
        @(negedge clock);
        chk("post_reset_tx", 32'(tx), 1);
        chk("post_reset_busy", 32'(busy), 0);
        chk("post_reset_rd_x", 32'(rd_x), 0);
        chk("post_reset_rd_y", 32'(rd_y), 0);
        chk("bytes_before_reset", 32'(rx_count), 4);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        repeat (10) @(negedge clock);
        chk("no_done_after_abort", 32'(done_cnt), 0);
        chk("tx_idle_after_abort", 32'(tx), 1);
        push_frame(8'h00, 8'h10, 8'h01, 8'h11);
        rx_count = 0;
        start = 1'b1;
        s = cyc;
        @(negedge clock);
        start = 1'b0;
        wait_done("dump_d", d);
        chk("duration_d", 32'(d - s + 1), TOTAL);
        repeat (20) @(negedge clock);
        chk("bytes_d", 32'(rx_count), 12);
        chk("done_count_d", 32'(done_cnt), 1);
        chk("sb_empty_d", 32'(exp_q.size()), 0);

        // Start coinciding with reset is ignored.
        rx_count = 0;
        done_cnt = 0;
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        chk("rst_start_bad_cycles", 32'(bad), 0);
        chk("rst_start_bytes", 32'(rx_count), 0);
        chk("rst_start_done", 32'(done_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_dump_uart.md
FRAME_DUMP_UART -- requirements
Module: frame_dump_uart

Interface
REQ-001 Parameter W_RES, default 640, frame width in pixels.
REQ-002 Parameter H_RES, default 480, frame height in pixels.
REQ-003 Parameter BAUD_DIV, default 434, clock cycles per UART bit time (50 MHz / 115200).
REQ-004 Parameter RD_LAT, default 1, buffer read latency in cycles, from coordinate change to valid data.
REQ-005 Port clock, input, 1, system clock; the block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port start, input, 1, one-cycle request to dump the whole frame.
REQ-008 Ports red_in, green_in, blue_in, input, 8 each, pixel data from the three colour buffers.
REQ-009 Ports rd_x, rd_y, output, 11 each, buffer read coordinates.
REQ-010 Port tx, output, 1, UART serial line, 8N1, idle high.
REQ-011 Port busy, output, 1, high while a dump is in progress.
REQ-012 Port done, output, 1, one-cycle pulse when a dump completes.

Function
REQ-013 The FSM SHALL have the states IDLE, ADDR, WAIT, LOAD, SEND, NEXT and FIN.
REQ-014 IDLE: tx=1, busy=0. On start=1, the block SHALL set rd_x=0 and rd_y=0, set busy=1 on the next cycle, and go to ADDR.
REQ-015 start SHALL be ignored in every state except IDLE.
REQ-016 ADDR/WAIT: the block SHALL hold rd_x and rd_y stable for RD_LAT cycles after the coordinate update, then go to LOAD.
REQ-017 LOAD: the block SHALL capture red_in, green_in and blue_in into a 24-bit pixel register in a single cycle, set the byte index to 0, and go to SEND.
REQ-018 SEND: the block SHALL transmit the bytes in the order R (index 0), G (1), B (2).
REQ-019 Byte frame: 1 start bit (0), then 8 data bits LSB-first, then 1 stop bit (1); each bit SHALL hold exactly BAUD_DIV cycles, so each byte takes 10*BAUD_DIV cycles.
REQ-020 Bits SHALL be transmitted back to back: the next start bit begins on the cycle after the previous stop bit ends, with no idle gap inside a pixel.
REQ-021 After the stop bit of byte 2, the FSM SHALL go to NEXT.
REQ-022 NEXT, raster order, x fastest:
  - if rd_x < W_RES-1: rd_x+1;
  - else rd_x=0 and rd_y+1;
  - then go to ADDR.
REQ-023 NEXT with rd_x=W_RES-1 and rd_y=H_RES-1 SHALL go to FIN instead, leaving the coordinates unchanged.
REQ-024 FIN: done=1 for exactly one cycle, busy=0 in that same cycle, tx=1; the next state SHALL be IDLE.
REQ-025 tx SHALL be driven from a register, with no combinational path from the inputs.
REQ-026 The bit counter SHALL count 0..BAUD_DIV-1 and wrap; the bit index SHALL count 0..9; the byte index SHALL count 0..2. None of these counters SHALL overflow their width.
REQ-027 Total dump duration from start to done SHALL be W_RES*H_RES*(RD_LAT + 3 + 30*BAUD_DIV) + 2 cycles, ±1 per pixel only if documented in the implementation header.
REQ-028 Changes on red_in, green_in or blue_in outside LOAD SHALL NOT affect transmitted data.

Reset
REQ-029 reset=1 SHALL override all states within one clock edge, including mid-byte.
REQ-030 Reset values: state=IDLE, tx=1, busy=0, done=0, rd_x=0, rd_y=0, all counters=0, pixel register=0.
REQ-031 A partially sent byte SHALL be abandoned on reset and SHALL NOT be resumed; tx SHALL be 1 on the cycle after reset is sampled.
REQ-032 start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-033 Bench parameters W_RES=2, H_RES=2, BAUD_DIV=4, RD_LAT=1; buffer model holds pixel (x,y) = R 0x10*x+y, G 0xA5, B 0x3C.
  - Stimulus: full-frame start. Required response: the bench UART decoder receives 12 bytes: 00 A5 3C, 10 A5 3C, 01 A5 3C, 11 A5 3C.
  - Required timing: done pulses once, busy falls with done, and total cycles match REQ-027.
REQ-034 Byte framing: data 0x81. Required response: tx low 4 cycles, then high 4, then low 24, then high 4 (data bit 7), then high 4 (stop bit), with no glitches.
REQ-035 start pulsed again while busy=1. Required response: byte count stays 12, and only one done pulse occurs.
REQ-036 reset asserted during bit 5 of the G byte of pixel (1,0). Required response:
  - next cycle: tx=1, busy=0, rd_x=rd_y=0;
  - a fresh start afterwards produces a complete, correct 12-byte dump.
REQ-037 red_in toggled every cycle except in the LOAD cycle. Required response: transmitted R bytes equal the values sampled in LOAD only.
REQ-038 reset and start high in the same cycle, then reset released. Required response: busy stays 0, and tx stays 1 for 100 cycles.
